// File: rtl/timer_alarm_core.sv
// Countdown alarm: loads a 2*DATA_W-bit period, counts down while enabled, raises a sticky level IRQ on expiry.
// Outputs are registered and update one cycle after a strobe; there is no backpressure, and cke_i = 0 freezes everything.
module timer_alarm_core #(
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic                  cke_i,
   input  logic                  ALARM_ENABLE,
   input  logic                  ALARM_LOAD,
   input  logic [2*DATA_W-1:0]   ALARM_PERIOD,
   input  logic                  ALARM_PERIODIC,
   input  logic                  ALARM_ACK,
   output logic [2*DATA_W-1:0]   ALARM_VALUE,
   output logic                  ALARM_IRQ,
   output logic                  ALARM_MISSED,
   output logic                  ALARM_BUSY
);

   localparam int CW = 2 * DATA_W;
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   counter, counter_nxt;
   logic [CW-1:0]   period_r, period_nxt;
   logic            periodic_r, periodic_nxt;
   logic            irq, irq_nxt;
   logic            missed, missed_nxt;
   logic            busy_r, busy_nxt;
   logic            expire;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state      <= IDLE;
         counter    <= '0;
         period_r   <= '0;
         periodic_r <= 1'b0;
         irq        <= 1'b0;
         missed     <= 1'b0;
         busy_r     <= 1'b0;
      end else if (cke_i) begin
         state      <= state_nxt;
         counter    <= counter_nxt;
         period_r   <= period_nxt;
         periodic_r <= periodic_nxt;
         irq        <= irq_nxt;
         missed     <= missed_nxt;
         busy_r     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      period_nxt   = period_r;
      periodic_nxt = periodic_r;
      irq_nxt      = irq;
      missed_nxt   = missed;
      expire       = 1'b0;

      // LOAD overrides any decrement or expiry in the same cycle
      if (ALARM_LOAD) begin
         if (ALARM_PERIOD != '0) begin
            counter_nxt  = ALARM_PERIOD;
            period_nxt   = ALARM_PERIOD;
            periodic_nxt = ALARM_PERIODIC;
            state_nxt    = RUN;
         end else begin
            counter_nxt = '0;
            state_nxt   = IDLE;
         end
      end else if (state == RUN && ALARM_ENABLE) begin
         if (counter > ONE) begin
            counter_nxt = counter - ONE;
         end else if (counter == ONE) begin
            expire = 1'b1;
            if (periodic_r) begin
               counter_nxt = period_r;
            end else begin
               counter_nxt = '0;
               state_nxt   = DONE;
            end
         end
      end

      // An ACK coincident with expiry consumes the previous event only
      if (expire) begin
         missed_nxt = ALARM_ACK ? 1'b0 : (missed | irq);
         irq_nxt    = 1'b1;
      end else if (ALARM_ACK) begin
         irq_nxt    = 1'b0;
         missed_nxt = 1'b0;
      end

      busy_nxt = (state_nxt == RUN);
   end

   assign ALARM_VALUE  = counter;
   assign ALARM_IRQ    = irq;
   assign ALARM_MISSED = missed;
   assign ALARM_BUSY   = busy_r;

endmodule

// File: tb/tb_timer_alarm_core.sv
// Bench for timer_alarm_core: reference alarm model compared every cycle, plus directed literal checks.
module tb_timer_alarm_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cke = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [63:0] per = '0;
   logic        periodic = 1'b0;
   logic        ack = 1'b0;
   logic [63:0] value;
   logic        irq, missed, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_alarm_core #(.DATA_W(32)) dut (
      .clk_i         (clk),
      .arst_n_i      (rst_n),
      .cke_i         (cke),
      .ALARM_ENABLE  (en),
      .ALARM_LOAD    (load),
      .ALARM_PERIOD  (per),
      .ALARM_PERIODIC(periodic),
      .ALARM_ACK     (ack),
      .ALARM_VALUE   (value),
      .ALARM_IRQ     (irq),
      .ALARM_MISSED  (missed),
      .ALARM_BUSY    (busy)
   );

   // Reference: remaining cycles until the next alarm, whether an alarm is armed, sticky event flags.
   longint unsigned remaining = 0;
   longint unsigned reload = 0;
   bit              auto_rearm = 0;
   bit              armed = 0;
   bit              ev_pending = 0;
   bit              ev_lost = 0;

   always @(posedge clk or negedge rst_n) begin
      bit fired;
      if (!rst_n) begin
         remaining = 0; reload = 0; auto_rearm = 0; armed = 0;
         ev_pending = 0; ev_lost = 0;
      end else if (cke) begin
         fired = 0;
         if (load) begin
            armed = (per != 0);
            remaining = per;
            if (per != 0) begin
               reload = per;
               auto_rearm = periodic;
            end
         end else if (armed && en) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
               fired = 1;
               armed = auto_rearm;
               if (auto_rearm) remaining = reload;
            end
         end
         if (fired) begin
            ev_lost = ack ? 1'b0 : ev_pending;
            ev_lost = ev_lost | (!ack && ev_lost);
            ev_pending = 1;
         end else if (ack) begin
            ev_pending = 0;
            ev_lost = 0;
         end
      end
   end

   // The lost flag is sticky across unacknowledged expiries.
   bit lost_sticky = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lost_sticky <= 0;
      else if (cke) begin
         if (ack) lost_sticky <= 0;
         else if (ev_lost) lost_sticky <= 1;
      end
   end

   always @(negedge clk) begin
      logic exp_missed;
      exp_missed = ev_lost | lost_sticky;
      checks = checks + 4;
      if (value !== remaining) begin
         errors++;
         $display("FAIL cyc_value t=%0t got %h exp %h", $time, value, remaining);
      end
      if (irq !== ev_pending) begin
         errors++;
         $display("FAIL cyc_irq t=%0t got %b exp %b", $time, irq, ev_pending);
      end
      if (missed !== exp_missed) begin
         errors++;
         $display("FAIL cyc_missed t=%0t got %b exp %b", $time, missed, exp_missed);
      end
      if (busy !== armed) begin
         errors++;
         $display("FAIL cyc_busy t=%0t got %b exp %b", $time, busy, armed);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end
   endtask

   task automatic do_load(input logic [63:0] p, input logic pm);
      per = p; periodic = pm; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(2);
      lit("rst_value", value, 64'd0);
      lit("rst_irq", {63'd0, irq}, 64'd0);
      lit("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      tick();

      // One-shot, period 5
      en = 1'b1;
      do_load(64'd5, 1'b0);
      lit("os_load_value", value, 64'd5);
      lit("os_load_busy", {63'd0, busy}, 64'd1);
      for (int j = 1; j < 5; j++) begin
         tick();
         lit("os_count", value, 64'(5 - j));
      end
      tick();
      lit("os_irq", {63'd0, irq}, 64'd1);
      lit("os_busy_done", {63'd0, busy}, 64'd0);
      lit("os_value_done", value, 64'd0);
      do_ack();
      lit("os_ack_irq", {63'd0, irq}, 64'd0);
      tick();
      lit("os_stay_done", value, 64'd0);

      // Periodic with overrun, period 3
      do_load(64'd3, 1'b1);
      tick(2);
      lit("per_k2", value, 64'd1);
      tick();
      lit("per_irq_k3", {63'd0, irq}, 64'd1);
      lit("per_reload_k3", value, 64'd3);
      lit("per_nomiss_k3", {63'd0, missed}, 64'd0);
      tick(3);
      lit("per_missed_k6", {63'd0, missed}, 64'd1);
      lit("per_reload_k6", value, 64'd3);
      do_ack();
      lit("per_ack_irq", {63'd0, irq}, 64'd0);
      lit("per_ack_missed", {63'd0, missed}, 64'd0);
      tick();
      lit("per_k8_irq", {63'd0, irq}, 64'd0);
      tick();
      lit("per_irq_k9", {63'd0, irq}, 64'd1);

      // Coincident ACK at expiry, then LOAD at expiry
      tick(2);
      lit("co_value1", value, 64'd1);
      do_ack();
      lit("co_ack_irq", {63'd0, irq}, 64'd1);
      lit("co_ack_missed", {63'd0, missed}, 64'd0);
      tick(2);
      do_load(64'd6, 1'b0);
      lit("co_load_value", value, 64'd6);
      lit("co_load_missed", {63'd0, missed}, 64'd0);
      do_ack();
      lit("co_clear_irq", {63'd0, irq}, 64'd0);

      // Stalls: two ENABLE-low cycles, one cke-low cycle
      do_load(64'd4, 1'b0);
      tick();
      lit("st_k1", value, 64'd3);
      en = 1'b0;
      tick(2);
      lit("st_en_hold", value, 64'd3);
      en = 1'b1; cke = 1'b0;
      tick();
      lit("st_cke_hold", value, 64'd3);
      cke = 1'b1;
      tick(2);
      lit("st_k6_value", value, 64'd1);
      lit("st_k6_irq", {63'd0, irq}, 64'd0);
      tick();
      lit("st_k7_irq", {63'd1, irq}, {63'd1, 1'b1});
      do_ack();

      // Cancel while running
      do_load(64'd10, 1'b0);
      tick(3);
      lit("cn_value7", value, 64'd7);
      do_load(64'd0, 1'b0);
      lit("cn_value0", value, 64'd0);
      lit("cn_busy", {63'd0, busy}, 64'd0);
      tick(10);
      lit("cn_no_irq", {63'd0, irq}, 64'd0);

      // Reset mid-count
      do_load(64'd4, 1'b0);
      tick(2);
      lit("rs_value2", value, 64'd2);
      #1 rst_n = 1'b0;
      #1;
      lit("rs_value_now", value, 64'd0);
      lit("rs_busy_now", {63'd0, busy}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick(5);
      lit("rs_no_irq", {63'd0, irq}, 64'd0);

      // Wide boundary
      do_load(64'h0000_0001_0000_0000, 1'b0);
      tick();
      lit("wd_borrow", value, 64'h0000_0000_FFFF_FFFF);
      do_load(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      tick();
      lit("wd_top", value, 64'hFFFF_FFFF_FFFF_FFFE);
      do_load(64'd2, 1'b0);
      tick();
      lit("wd_end1", value, 64'd1);
      tick();
      lit("wd_end_irq", {63'd0, irq}, 64'd1);
      do_ack();

      // Period 1, periodic
      do_load(64'd1, 1'b1);
      lit("p1_value", value, 64'd1);
      tick();
      lit("p1_irq", {63'd0, irq}, 64'd1);
      lit("p1_nomiss", {63'd0, missed}, 64'd0);
      tick();
      lit("p1_missed", {63'd0, missed}, 64'd1);
      do_ack();
      lit("p1_ack_irq", {63'd0, irq}, 64'd1);
      lit("p1_ack_missed", {63'd0, missed}, 64'd0);
      do_load(64'd0, 1'b0);
      do_ack();
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
